// File: rtl/padlock_pkg.sv
// Shared types and width helpers for the sequential combination lock.
package padlock_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        UNLOCKED = 2'd1,
        PROGRAM  = 2'd2,
        LOCKOUT  = 2'd3
    } padlock_state_t;

    // Width of the symbol index; a one-symbol code still gets a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

    // Width of a down-counter that must hold cycles-1.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    // Width of the remaining-tries counter, which must hold 0..max_tries.
    function automatic int unsigned tries_width(input int unsigned max_tries);
        return $clog2(max_tries + 1);
    endfunction

endpackage

// File: rtl/padlock_seq_lockout_timer.sv
// Lockout down-counter: load on entry, count to zero, flag done at zero.
module padlock_lockout_timer
    import padlock_pkg::*;
#(
    parameter int unsigned LOCKOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done_c
);

    localparam int unsigned CW = cnt_width(LOCKOUT_CYCLES);
    localparam logic [CW-1:0] LOAD_VAL = CW'(LOCKOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Load takes precedence; otherwise decrement and rest at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = LOAD_VAL;
        end else if (count_q != '0) begin
            count_d = count_q - CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_c = (count_q == '0);

endmodule

// File: rtl/padlock_seq.sv
// Sequential combination lock with reprogrammable code, try counter and timed lockout.
module padlock_seq
    import padlock_pkg::*;
#(
    parameter int unsigned DIGIT_W        = 4,
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DIGIT_W-1:0]                   digit_in,
    input  logic                                 digit_valid,
    input  logic                                 clear,
    input  logic                                 lock_cmd,
    input  logic                                 prog,
    output logic                                 unlocked,
    output logic                                 locked_out,
    output logic                                 error,
    output logic [tries_width(MAX_TRIES)-1:0]    tries_left,
    output logic                                 programming
);

    localparam int unsigned IW = idx_width(DIGITS);
    localparam int unsigned TW = tries_width(MAX_TRIES);
    localparam int unsigned CODE_W = DIGITS * DIGIT_W;

    padlock_state_t      state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                miss_q, miss_d;
    logic [TW-1:0]       tries_q, tries_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CODE_W-1:0]   shadow_q, shadow_d;
    logic                unlocked_q, unlocked_d;
    logic                locked_out_q, locked_out_d;
    logic                error_q, error_d;
    logic                programming_q, programming_d;

    logic                timer_load;
    logic                timer_done_c;
    logic                last_c;
    logic                miss_nxt;
    logic [DIGIT_W-1:0]  code_digit;
    logic [CODE_W-1:0]   shadow_wr;

    padlock_lockout_timer #(
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .done_c (timer_done_c)
    );

    // Current code symbol and shadow with the incoming symbol merged in.
    always_comb begin
        code_digit = '0;
        shadow_wr  = shadow_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IW'(i)) begin
                code_digit                      = code_q[i*DIGIT_W +: DIGIT_W];
                shadow_wr[i*DIGIT_W +: DIGIT_W] = digit_in;
            end
        end
    end

    // Next-state, datapath and registered-output decode; clear outranks every other input.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        miss_d     = miss_q;
        tries_d    = tries_q;
        code_d     = code_q;
        shadow_d   = shadow_q;
        error_d    = 1'b0;
        timer_load = 1'b0;
        last_c     = (idx_q == IW'(DIGITS - 1));
        miss_nxt   = miss_q | (digit_in != code_digit);

        unique case (state_q)
            LOCKED: begin
                if (clear) begin
                    idx_d  = '0;
                    miss_d = 1'b0;
                end else if (digit_valid) begin
                    if (last_c) begin
                        idx_d  = '0;
                        miss_d = 1'b0;
                        if (!miss_nxt) begin
                            state_d = UNLOCKED;
                            tries_d = TW'(MAX_TRIES);
                        end else begin
                            error_d = 1'b1;
                            tries_d = tries_q - TW'(1);
                            if (tries_q == TW'(1)) begin
                                state_d    = LOCKOUT;
                                timer_load = 1'b1;
                            end
                        end
                    end else begin
                        idx_d  = idx_q + IW'(1);
                        miss_d = miss_nxt;
                    end
                end
            end
            UNLOCKED: begin
                if (clear) begin
                    state_d = UNLOCKED;
                end else if (lock_cmd) begin
                    state_d = LOCKED;
                end else if (prog) begin
                    state_d  = PROGRAM;
                    idx_d    = '0;
                    shadow_d = '0;
                end
            end
            PROGRAM: begin
                if (clear) begin
                    idx_d    = '0;
                    shadow_d = '0;
                end else if (lock_cmd) begin
                    state_d  = LOCKED;
                    idx_d    = '0;
                    shadow_d = '0;
                end else if (digit_valid) begin
                    if (last_c) begin
                        code_d   = shadow_wr;
                        shadow_d = '0;
                        idx_d    = '0;
                        state_d  = UNLOCKED;
                    end else begin
                        shadow_d = shadow_wr;
                        idx_d    = idx_q + IW'(1);
                    end
                end
            end
            LOCKOUT: begin
                if (timer_done_c) begin
                    state_d = LOCKED;
                    tries_d = TW'(MAX_TRIES);
                end
            end
            default: state_d = LOCKED;
        endcase

        unlocked_d    = (state_d == UNLOCKED) || (state_d == PROGRAM);
        locked_out_d  = (state_d == LOCKOUT);
        programming_d = (state_d == PROGRAM);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= LOCKED;
            idx_q         <= '0;
            miss_q        <= 1'b0;
            tries_q       <= TW'(MAX_TRIES);
            code_q        <= '0;
            shadow_q      <= '0;
            unlocked_q    <= 1'b0;
            locked_out_q  <= 1'b0;
            error_q       <= 1'b0;
            programming_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            miss_q        <= miss_d;
            tries_q       <= tries_d;
            code_q        <= code_d;
            shadow_q      <= shadow_d;
            unlocked_q    <= unlocked_d;
            locked_out_q  <= locked_out_d;
            error_q       <= error_d;
            programming_q <= programming_d;
        end
    end

    assign unlocked    = unlocked_q;
    assign locked_out  = locked_out_q;
    assign error       = error_q;
    assign tries_left  = tries_q;
    assign programming = programming_q;

endmodule

// File: tb/tb_padlock_seq.sv
// Scoreboarded bench for padlock_seq: every output change must match a queued expectation at an exact cycle.
module tb_padlock_seq;

    typedef struct packed {
        logic       unl;
        logic       lo;
        logic       err;
        logic [1:0] tl;
        logic       prg;
    } obs_t;

    typedef struct {
        string name;
        int    cyc;
        obs_t  o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] digit_in = '0;
    logic       digit_valid = 1'b0;
    logic       clear = 1'b0;
    logic       lock_cmd = 1'b0;
    logic       prog = 1'b0;
    logic       unlocked, locked_out, error, programming;
    logic [1:0] tries_left;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails = 0;
    bit   mon_en = 1'b0;
    obs_t prev;
    exp_t q[$];

    padlock_seq #(
        .DIGIT_W        (4),
        .DIGITS         (4),
        .MAX_TRIES      (3),
        .LOCKOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .clear       (clear),
        .lock_cmd    (lock_cmd),
        .prog        (prog),
        .unlocked    (unlocked),
        .locked_out  (locked_out),
        .error       (error),
        .tries_left  (tries_left),
        .programming (programming)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t mk(input logic u, input logic lo, input logic e,
                                input logic [1:0] t, input logic p);
        obs_t r;
        r.unl = u; r.lo = lo; r.err = e; r.tl = t; r.prg = p;
        return r;
    endfunction

    function automatic obs_t cur_obs();
        return mk(unlocked, locked_out, error, tries_left, programming);
    endfunction

    // Monitor: any change of the observed outputs is an event and must match the queue head.
    always @(negedge clk) begin
        obs_t cur;
        exp_t e;
        if (mon_en) begin
            cur = cur_obs();
            if (cur !== prev) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fails++;
                    $display("FAIL unexpected_event cyc=%0d got=%b prev=%b", cyc, cur, prev);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || cur !== e.o) begin
                        n_fails++;
                        $display("FAIL %s: got cyc=%0d outs=%b, required cyc=%0d outs=%b",
                                 e.name, cyc, cur, e.cyc, e.o);
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic push(input string n, input int c, input obs_t o);
        exp_t e;
        e.name = n; e.cyc = c; e.o = o;
        q.push_back(e);
    endtask

    task automatic check(input string n, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_fails++;
            $display("FAIL %s: got %0d, required %0d", n, got, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic digit(input logic [3:0] d);
        digit_in = d;
        digit_valid = 1'b1;
        @(negedge clk);
        digit_valid = 1'b0;
    endtask

    task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        digit(a); digit(b); digit(c); digit(d);
    endtask

    task automatic pulse_lock();
        lock_cmd = 1'b1;
        @(negedge clk);
        lock_cmd = 1'b0;
    endtask

    task automatic pulse_prog();
        prog = 1'b1;
        @(negedge clk);
        prog = 1'b0;
    endtask

    // Asynchronous reset between edges; outputs must drop before the next clock edge.
    task automatic async_reset(input string n);
        push(n, cyc + 1, mk(0, 0, 0, 2'd3, 0));
        #2 rst = 1'b1;
        #1;
        check({n, "_unlocked_now"}, int'(unlocked), 0);
        check({n, "_locked_out_now"}, int'(locked_out), 0);
        check({n, "_programming_now"}, int'(programming), 0);
        check({n, "_tries_now"}, int'(tries_left), 3);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c3;
        step(2);
        rst = 1'b0;
        check("reset_unlocked", int'(unlocked), 0);
        check("reset_locked_out", int'(locked_out), 0);
        check("reset_error", int'(error), 0);
        check("reset_programming", int'(programming), 0);
        check("reset_tries", int'(tries_left), 3);
        prev = mk(0, 0, 0, 2'd3, 0);
        mon_en = 1'b1;
        step(1);

        // Default all-zero code unlocks one cycle after the 4th strobe.
        push("unlock_default", cyc + 4, mk(1, 0, 0, 2'd3, 0));
        enter4(0, 0, 0, 0);

        // Program 3,1,4,1 and relock.
        push("prog_enter", cyc + 1, mk(1, 0, 0, 2'd3, 1));
        pulse_prog();
        push("prog_commit", cyc + 4, mk(1, 0, 0, 2'd3, 0));
        enter4(3, 1, 4, 1);
        push("relock1", cyc + 1, mk(0, 0, 0, 2'd3, 0));
        pulse_lock();

        // Old code now fails, new code unlocks (back-to-back entries).
        push("old_code_err", cyc + 4, mk(0, 0, 1, 2'd2, 0));
        push("old_code_err_end", cyc + 5, mk(0, 0, 0, 2'd2, 0));
        enter4(0, 0, 0, 0);
        push("new_code_unlock", cyc + 4, mk(1, 0, 0, 2'd3, 0));
        enter4(3, 1, 4, 1);

        // Three failures lead to a 16-cycle lockout that ignores all symbols.
        push("relock2", cyc + 1, mk(0, 0, 0, 2'd3, 0));
        pulse_lock();
        push("fail1", cyc + 4, mk(0, 0, 1, 2'd2, 0));
        push("fail1_end", cyc + 5, mk(0, 0, 0, 2'd2, 0));
        enter4(9, 9, 9, 9);
        push("fail2", cyc + 4, mk(0, 0, 1, 2'd1, 0));
        push("fail2_end", cyc + 5, mk(0, 0, 0, 2'd1, 0));
        enter4(9, 9, 9, 9);
        c3 = cyc;
        push("fail3_lockout", c3 + 4, mk(0, 1, 1, 2'd0, 0));
        push("fail3_err_end", c3 + 5, mk(0, 1, 0, 2'd0, 0));
        push("lockout_end", c3 + 20, mk(0, 0, 0, 2'd3, 0));
        enter4(9, 9, 9, 9);
        enter4(3, 1, 4, 1);
        step(8);
        enter4(3, 1, 4, 1);
        check("lockout_exit_cycle", cyc, c3 + 20);
        push("post_lockout_unlock", cyc + 4, mk(1, 0, 0, 2'd3, 0));
        enter4(3, 1, 4, 1);

        // Clear with a coincident strobe drops that symbol and keeps tries.
        push("relock3", cyc + 1, mk(0, 0, 0, 2'd3, 0));
        pulse_lock();
        push("pre_clear_err", cyc + 4, mk(0, 0, 1, 2'd2, 0));
        push("pre_clear_err_end", cyc + 5, mk(0, 0, 0, 2'd2, 0));
        enter4(9, 9, 9, 9);
        digit(3);
        digit(1);
        clear = 1'b1;
        digit(4);
        clear = 1'b0;
        check("clear_keeps_tries", int'(tries_left), 2);
        push("clear_then_unlock", cyc + 4, mk(1, 0, 0, 2'd3, 0));
        enter4(3, 1, 4, 1);

        // Program abort keeps the old code.
        push("abort_prog_enter", cyc + 1, mk(1, 0, 0, 2'd3, 1));
        pulse_prog();
        digit(7);
        digit(7);
        push("abort_relock", cyc + 1, mk(0, 0, 0, 2'd3, 0));
        pulse_lock();
        push("abort_old_unlock", cyc + 4, mk(1, 0, 0, 2'd3, 0));
        enter4(3, 1, 4, 1);

        // lock_cmd coincident with prog relocks.
        push("lock_beats_prog", cyc + 1, mk(0, 0, 0, 2'd3, 0));
        lock_cmd = 1'b1;
        prog = 1'b1;
        step(1);
        lock_cmd = 1'b0;
        prog = 1'b0;

        // Async reset mid-program restores the all-zero code.
        push("rst_prog_unlock", cyc + 4, mk(1, 0, 0, 2'd3, 0));
        enter4(3, 1, 4, 1);
        push("rst_prog_enter", cyc + 1, mk(1, 0, 0, 2'd3, 1));
        pulse_prog();
        digit(5);
        digit(5);
        async_reset("rst_mid_program");
        push("zero_after_rst1", cyc + 4, mk(1, 0, 0, 2'd3, 0));
        enter4(0, 0, 0, 0);

        // Async reset mid-lockout after programming 1,2,3,4.
        push("prog2_enter", cyc + 1, mk(1, 0, 0, 2'd3, 1));
        pulse_prog();
        push("prog2_commit", cyc + 4, mk(1, 0, 0, 2'd3, 0));
        enter4(1, 2, 3, 4);
        push("relock4", cyc + 1, mk(0, 0, 0, 2'd3, 0));
        pulse_lock();
        push("lo_fail1", cyc + 4, mk(0, 0, 1, 2'd2, 0));
        push("lo_fail1_end", cyc + 5, mk(0, 0, 0, 2'd2, 0));
        enter4(0, 0, 0, 0);
        push("lo_fail2", cyc + 4, mk(0, 0, 1, 2'd1, 0));
        push("lo_fail2_end", cyc + 5, mk(0, 0, 0, 2'd1, 0));
        enter4(0, 0, 0, 0);
        push("lo_fail3", cyc + 4, mk(0, 1, 1, 2'd0, 0));
        push("lo_fail3_end", cyc + 5, mk(0, 1, 0, 2'd0, 0));
        enter4(0, 0, 0, 0);
        step(3);
        async_reset("rst_mid_lockout");
        push("zero_after_rst2", cyc + 4, mk(1, 0, 0, 2'd3, 0));
        enter4(0, 0, 0, 0);

        step(4);
        check("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/padlock_seq.md
# padlock_seq

Parametrised sequential combination lock, the successor to the 3-bit static padlock. The user enters a code of `DIGITS` symbols, each `DIGIT_W` bits wide, one per `digit_valid` strobe. The code is reprogrammable only while unlocked. Failed attempts are counted, and exhausting them triggers a timed lockout. The block sits between the input-pin decoder and the status LED/segment drivers, with all outputs registered.

## Interface
- `DIGIT_W`, default 4: width of one code symbol.
- `DIGITS`, default 4: number of symbols per code (≥1).
- `MAX_TRIES`, default 3: failed attempts allowed before lockout (≥1).
- `LOCKOUT_CYCLES`, default 16: lockout duration in clock cycles (≥1).

Ports:
- `clk` in 1: single clock, all state on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `digit_in` in `DIGIT_W`: symbol value, sampled when `digit_valid`=1.
- `digit_valid` in 1: one-cycle strobe, one symbol per high cycle.
- `clear` in 1: abandon the current entry without consuming a try.
- `lock_cmd` in 1: relock from UNLOCKED, or abort PROGRAM.
- `prog` in 1: request program mode; honoured only in UNLOCKED.
- `unlocked` out 1: high in UNLOCKED and PROGRAM.
- `locked_out` out 1: high in LOCKOUT.
- `error` out 1: one-cycle pulse on a failed attempt.
- `tries_left` out `$clog2(MAX_TRIES+1)`: remaining attempts.
- `programming` out 1: high in PROGRAM.

## Operation
States:
- **LOCKED**
  - Each `digit_valid` compares `digit_in` with `code[idx]`. Any mismatch sets a sticky `miss` flag. `idx` increments.
  - On the DIGITS-th symbol with `miss`=0: go to UNLOCKED and reload `tries_left` to MAX_TRIES.
  - On the DIGITS-th symbol with `miss`=1: pulse `error` and decrement `tries_left`. If the result is 0, go to LOCKOUT; otherwise stay in LOCKED.
  - `idx` and `miss` always clear after the DIGITS-th symbol.
- **UNLOCKED**
  - `lock_cmd` goes to LOCKED.
  - Otherwise `prog` goes to PROGRAM with `idx`=0.
  - `digit_valid` is ignored.
- **PROGRAM**
  - Each `digit_valid` writes `digit_in` to `shadow[idx]`.
  - After the DIGITS-th symbol, `shadow` commits to `code` in one cycle and the state returns to UNLOCKED.
  - `lock_cmd` discards `shadow`, leaves `code` unchanged, and goes to LOCKED.
- **LOCKOUT**
  - A down-counter loads LOCKOUT_CYCLES-1 on entry.
  - When the counter reaches 0, reload `tries_left` to MAX_TRIES and go to LOCKED.
  - All inputs are ignored.

Rules:
- `clear` resets `idx` and `miss` in LOCKED and PROGRAM. `shadow` is discarded. State and `tries_left` are unchanged.
- Priority, highest first: `rst` > `clear` > `lock_cmd` > `prog` > `digit_valid`.
  - A `clear` coincident with `digit_valid` drops the symbol.
  - A `lock_cmd` coincident with `prog` relocks.
- Reset values:
  - state LOCKED, `code` all zeros, `shadow` 0, `idx` 0, `miss` 0, `tries_left` MAX_TRIES.
  - Outputs: `unlocked`=0, `locked_out`=0, `error`=0, `programming`=0.
- Asserting `rst` mid-entry, mid-program, or mid-lockout returns to the reset state immediately. A partial program never reaches `code`.

## Timing
- All outputs are registered. A state change caused by an input sampled at edge N is visible after edge N.
- **Unlock latency:** `unlocked` rises 1 cycle after the final symbol's strobe edge.
- **Error timing:** `error` pulses for exactly 1 cycle, concurrent with the `tries_left` decrement.
- **Back-to-back strobes:** `digit_valid` may be high every cycle. A new entry may start the cycle after a failed attempt completes.
- **Lockout duration:** `locked_out` is high for exactly LOCKOUT_CYCLES cycles. Symbols accepted from the following cycle.
- **Program commit:** the new code is effective for any entry made after returning to UNLOCKED, so after a relock.

## Structure
- Package `padlock_pkg`:
  - state enum `padlock_state_t` {LOCKED, UNLOCKED, PROGRAM, LOCKOUT}.
  - `idx` and counter width helper functions.
- Sub-module `padlock_lockout_timer`: load/count-down/done, parametrised by LOCKOUT_CYCLES.
- `code` and `shadow` are packed `DIGITS*DIGIT_W` flop vectors. No memory macros.

## Test plan
- **Reset unlock:** reset, enter 0,0,0,0 → `unlocked`=1 one cycle after the 4th strobe; `tries_left`=3.
- **Program and relock:** unlock, `prog`, enter 3,1,4,1, `lock_cmd`. Then enter 0,0,0,0 → `error` pulse, `tries_left`=2. Then enter 3,1,4,1 → `unlocked`=1.
- **Lockout:** 3 wrong codes → third `error` with `tries_left`=0 and `locked_out`=1 for exactly 16 cycles, during which the correct code is ignored. Afterwards `tries_left`=3 and the correct code unlocks.
- **Clear:** enter 2 symbols, assert `clear` coincident with a 3rd `digit_valid`, then enter the correct 4 → unlock; `tries_left` unchanged.
- **Program abort:** in PROGRAM after 2 symbols assert `lock_cmd` → LOCKED; the old code still unlocks.
- **Async reset:** assert `rst` mid-lockout and mid-program → immediate reset values; `code` back to all zeros.
